alu_resp_unit: RTL and testbench

ALU_RESP_UNIT -- requirements
Module: alu_resp_unit

---
 rtl/alu_resp_unit.sv | 164 ++++++++++++++++
 tb/tb_alu_resp_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_resp_unit                                                 |
// | Purpose  : 32-bit ALU with a valid/ready request side and a valid/ready  |
// |            result side. Non-shift ops complete in one cycle. Shifts run  |
// |            iteratively at one bit per cycle, unless the build macro      |
// |            ALU_RESP_FAST_SHIFT_EN is defined. That macro selects a       |
// |            single-cycle barrel shifter.                                  |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            req_valid/req_ready, in1, in2, alu_sel  - request side        |
// |            res_valid/res_ready, alu_out, res_err   - result side         |
// |            busy                                    - state is not IDLE   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_resp_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  alu_sel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] alu_out,
  output logic        res_err,
  output logic        busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q,  data_d;   // working shift register
  logic [4:0]  cnt_q,   cnt_d;    // remaining shift steps
  logic [3:0]  op_q,    op_d;     // captured opcode
  logic [31:0] res_q,   res_d;    // held result
  logic        err_q,   err_d;

  // Single-cycle result computed from the live request inputs.
  logic [31:0] w_alu_res;
  logic        w_legal;
  logic        w_is_shift;

  always_comb begin
    w_alu_res  = 32'h0;
    w_legal    = 1'b1;
    w_is_shift = 1'b0;
    case (alu_sel)
      OP_ADD: w_alu_res = in1 + in2;
      OP_SUB: w_alu_res = in1 - in2;
      OP_SLT: w_alu_res = ($signed(in1) < $signed(in2)) ? 32'h1 : 32'h0;
      OP_XOR: w_alu_res = in1 ^ in2;
      OP_OR:  w_alu_res = in1 | in2;
      OP_AND: w_alu_res = in1 & in2;
`ifdef ALU_RESP_FAST_SHIFT_EN
      OP_SLL: w_alu_res = in1 << in2[4:0];
      OP_SRL: w_alu_res = in1 >> in2[4:0];
      OP_SRA: w_alu_res = $signed(in1) >>> in2[4:0];
`else
      // Iterative build: this value is only used when the shift amount is
      // zero, in which case the result is the operand itself.
      OP_SLL, OP_SRL, OP_SRA: begin
        w_alu_res  = in1;
        w_is_shift = 1'b1;
      end
`endif
      default: w_legal = 1'b0;
    endcase
  end

  // One-bit shift step of the working register.
  logic [31:0] w_step;

  always_comb begin
    w_step = data_q;
    case (op_q)
      OP_SLL:  w_step = {data_q[30:0], 1'b0};
      OP_SRL:  w_step = {1'b0, data_q[31:1]};
      default: w_step = {data_q[31], data_q[31:1]};   // SRA: sign fill
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = alu_sel;
          if (w_is_shift && (in2[4:0] != 5'd0)) begin
            state_d = SHIFT;
            data_d  = in1;
            cnt_d   = in2[4:0];
          end else begin
            state_d = DONE;
            res_d   = w_alu_res;
            err_d   = ~w_legal;
          end
        end
      end
      SHIFT: begin
        // The final step and the move to DONE share a cycle, so a shift of
        // N bits spends N cycles here and reports after N+1 cycles.
        data_d = w_step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
          res_d   = w_step;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
      cnt_q   <= 5'd0;
      op_q    <= 4'h0;
      res_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // The unit accepts requests only in IDLE. After a handshake in DONE, the
  // unit returns to IDLE first, so req_ready rises one cycle later.
  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign alu_out   = res_q;
  assign res_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_resp_unit.sv
`default_nettype none
module tb_alu_resp_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  alu_sel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] alu_out;
  logic        res_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_resp_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .in1       (in1),
    .in2       (in2),
    .alu_sel   (alu_sel),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .alu_out   (alu_out),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_err(input logic [3:0] op);
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9});
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_RESP_FAST_SHIFT_EN
    return 1;
`else
    if (op inside {4'd2, 4'd6, 4'd7}) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // ---------------- driver ----------------
  // Offers one request just before a rising edge. Scrambles the inputs after
  // acceptance and optionally pulses req_valid during the wait. Applies bp
  // cycles of backpressure, then completes the handshake. It reports what it
  // observed. It does no checking itself.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp, input int pulse_at,
                        output int lat, output logic [31:0] out, output logic err,
                        output bit rdy0, output bit wait_ok, output bit hold_ok, output bit bubble_ok);
    rdy0      = (req_ready === 1'b1);
    req_valid = 1'b1;
    in1       = a;
    in2       = b;
    alu_sel   = op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    in1       = $urandom;
    in2       = $urandom;
    alu_sel   = 4'($urandom);
    lat       = 1;
    wait_ok   = 1'b1;
    while (res_valid !== 1'b1 && lat < 100) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) wait_ok = 1'b0;
      if (lat == pulse_at) req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat++;
    end
    if (req_ready !== 1'b0 || busy !== 1'b1) wait_ok = 1'b0;
    out     = alu_out;
    err     = res_err;
    hold_ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || alu_out !== out || res_err !== err || req_ready !== 1'b0) hold_ok = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    bubble_ok = (req_ready === 1'b1) && (res_valid === 1'b0) && (busy === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    in1 = 32'h0; in2 = 32'h0; alu_sel = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || alu_out !== 32'h0 || res_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b out=%h err=%b busy=%b, want 1 0 00000000 0 0",
               req_ready, res_valid, alu_out, res_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_ops;
    int lat; logic [31:0] out; logic err; bit r0, w, h, bb;
    logic [3:0]  ops [4] = '{4'd0, 4'd1, 4'd3, 4'd7};
    logic [31:0] as  [4] = '{32'hA, 32'hA, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bs  [4] = '{32'hA, 32'hA, 32'h1, 32'h4};
    logic [31:0] exp [4] = '{32'h14, 32'h0, 32'h1, 32'hF8000000};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 0, -1, lat, out, err, r0, w, h, bb);
      total++;
      if (out !== exp[i] || err !== 1'b0) begin
        bad++;
        $display("FAIL basic_result[%0d]: got out=%h err=%b, want out=%h err=0", i, out, err, exp[i]);
      end
      total++;
      if (lat !== model_lat(ops[i], bs[i])) begin
        bad++;
        $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, model_lat(ops[i], bs[i]));
      end
      total++;
      if (!r0 || !bb) begin
        bad++;
        $display("FAIL basic_ready[%0d]: got ready_before=%0d bubble_ok=%0d, want 1 1", i, r0, bb);
      end
    end
  endtask

  task automatic test_long_shift;
    int lat; logic [31:0] out; logic err; bit r0, w, h, bb;
    run_op(4'd2, 32'h1, 32'd31, 0, 10, lat, out, err, r0, w, h, bb);
    total++;
    if (out !== 32'h80000000 || err !== 1'b0) begin
      bad++;
      $display("FAIL sll31_result: got out=%h err=%b, want 80000000 0", out, err);
    end
    total++;
    if (lat !== model_lat(4'd2, 32'd31)) begin
      bad++;
      $display("FAIL sll31_busy_cycles: got %0d want %0d", lat, model_lat(4'd2, 32'd31));
    end
    total++;
    if (!w) begin
      bad++;
      $display("FAIL sll31_busy_ready: got busy/ready flag=%0d, want 1 (busy=1, req_ready=0 throughout)", w);
    end
    total++;
    if (!bb) begin
      bad++;
      $display("FAIL sll31_after: got req_ready=%b res_valid=%b busy=%b, want 1 0 0", req_ready, res_valid, busy);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] out; logic err; bit r0, w, h, bb;
    run_op(4'd5, 32'hFFFF0000, 32'h0F0F0F0F, 10, -1, lat, out, err, r0, w, h, bb);
    total++;
    if (out !== 32'hF0F00F0F || err !== 1'b0 || lat !== 1) begin
      bad++;
      $display("FAIL bp_xor: got out=%h err=%b lat=%0d, want F0F00F0F 0 1", out, err, lat);
    end
    total++;
    if (!h) begin
      bad++;
      $display("FAIL bp_hold: got hold flag=%0d, want 1 (output stable for 10 cycles)", h);
    end
    total++;
    if (!bb) begin
      bad++;
      $display("FAIL bp_bubble: got req_ready=%b res_valid=%b, want 1 0", req_ready, res_valid);
    end
  endtask

  task automatic test_illegal;
    int lat; logic [31:0] out; logic err; bit r0, w, h, bb;
    run_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, 2, -1, lat, out, err, r0, w, h, bb);
    total++;
    if (out !== 32'h0 || err !== 1'b1 || lat !== 1) begin
      bad++;
      $display("FAIL illegal_op: got out=%h err=%b lat=%0d, want 00000000 1 1", out, err, lat);
    end
    run_op(4'd9, 32'hFF, 32'h0F, 0, -1, lat, out, err, r0, w, h, bb);
    total++;
    if (out !== 32'h0F || err !== 1'b0 || lat !== 1) begin
      bad++;
      $display("FAIL and_after_illegal: got out=%h err=%b lat=%0d, want 0000000F 0 1", out, err, lat);
    end
  endtask

  task automatic test_reset_midshift;
    int lat; logic [31:0] out; logic err; bit r0, w, h, bb;
    // Leave a nonzero result held so that clearing it by reset is visible.
    run_op(4'd8, 32'h5A5A0000, 32'h00005A5A, 0, -1, lat, out, err, r0, w, h, bb);
    req_valid = 1'b1; in1 = 32'hDEADBEEF; in2 = 32'd20; alu_sel = 4'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    total++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || alu_out !== 32'h0 || res_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midshift_reset: got rdy=%b vld=%b out=%h err=%b busy=%b, want 1 0 00000000 0 0",
               req_ready, res_valid, alu_out, res_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd0, 32'h1, 32'h1, 0, -1, lat, out, err, r0, w, h, bb);
    total++;
    if (out !== 32'h2 || err !== 1'b0 || lat !== 1 || !r0) begin
      bad++;
      $display("FAIL add_after_reset: got out=%h err=%b lat=%0d rdy=%0d, want 00000002 0 1 1", out, err, lat, r0);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] out; logic err; bit r0, w, h, bb;
    logic [3:0] op; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
      run_op(op, a, b, $urandom_range(0, 3), $urandom_range(1, 8), lat, out, err, r0, w, h, bb);
      total++;
      if (out !== model_res(op, a, b) || err !== model_err(op)) begin
        bad++;
        $display("FAIL rand_result[%0d] op=%h a=%h b=%h: got out=%h err=%b, want out=%h err=%b",
                 i, op, a, b, out, err, model_res(op, a, b), model_err(op));
      end
      total++;
      if (lat !== model_lat(op, b) || !h || !bb || !r0 || !w) begin
        bad++;
        $display("FAIL rand_timing[%0d] op=%h: got lat=%0d hold=%0d bubble=%0d rdy=%0d busy_ok=%0d, want lat=%0d and all flags 1",
                 i, op, lat, h, bb, r0, w, model_lat(op, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_long_shift();
    test_backpressure();
    test_illegal();
    test_reset_midshift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
